// File: rtl/fifo_burst_reader_if.sv
// AXI-Stream style output bundle of fifo_burst_reader.
// master drives tdata/tvalid/tlast/tuser, slave drives tready.
interface fifo_burst_reader_if #(
   parameter int DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] tdata_o;
   logic                  tvalid_o;
   logic                  tlast_o;
   logic                  tuser_o;
   logic                  tready_i;

   modport master (
      output tdata_o,
      output tvalid_o,
      output tlast_o,
      output tuser_o,
      input  tready_i
   );

   modport slave (
      input  tdata_o,
      input  tvalid_o,
      input  tlast_o,
      input  tuser_o,
      output tready_i
   );
endinterface

// File: rtl/fifo_burst_reader.sv
// Drains a show-ahead FIFO as stream bursts of BURST_LEN beats,
// flushing a shorter tuser-flagged burst after TIMEOUT idle cycles.
// Ports: clk_i, rst_i (async, active-high), FIFO side
//   fifo_rd_data_i / fifo_used_words_i / fifo_empty_i / fifo_rd_o,
//   axis (master: tdata/tvalid/tlast/tuser out, tready in), busy_o.
module fifo_burst_reader #(
   parameter int DATA_WIDTH   = 8,
   parameter int WORDS_AMOUNT = 8,
   parameter int ADDR_WIDTH   = $clog2(WORDS_AMOUNT),
   parameter int BURST_LEN    = 4,
   parameter int TIMEOUT      = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [DATA_WIDTH-1:0] fifo_rd_data_i,
   input  logic [ADDR_WIDTH:0]   fifo_used_words_i,
   input  logic                  fifo_empty_i,
   output logic                  fifo_rd_o,
   fifo_burst_reader_if.master   axis,
   output logic                  busy_o
);

   localparam int WCW =
      (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   localparam logic [ADDR_WIDTH:0] LEN_FULL =
      (ADDR_WIDTH + 1)'(BURST_LEN);
   localparam logic [ADDR_WIDTH:0] PL_ONE =
      (ADDR_WIDTH + 1)'(1);
   localparam logic [WCW-1:0] WAIT_MAX =
      WCW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [WCW-1:0] W_ONE = WCW'(1);
   localparam bit TMO_EN = (TIMEOUT != 0);

   typedef enum logic {
      IDLE,
      BURST
   } state_t;

   state_t                state;
   logic [ADDR_WIDTH:0]   pop_left;
   logic [WCW-1:0]        wait_cnt;
   logic                  partial;

   logic [DATA_WIDTH-1:0] tdata_q;
   logic                  tvalid_q;
   logic                  tlast_q;
   logic                  tuser_q;

   logic                  pop;
   logic                  full_go;
   logic                  tmo_go;

   // Pop only when the output stage is free or
   // being drained in this same cycle.
   assign pop = (state == BURST)
             && (pop_left != '0)
             && !fifo_empty_i
             && (!tvalid_q || axis.tready_i);

   assign full_go = (fifo_used_words_i >= LEN_FULL);

   assign tmo_go = TMO_EN
                && !fifo_empty_i
                && (wait_cnt == WAIT_MAX);

   assign fifo_rd_o     = pop;
   assign busy_o        = (state == BURST);
   assign axis.tdata_o  = tdata_q;
   assign axis.tvalid_o = tvalid_q;
   assign axis.tlast_o  = tlast_q;
   assign axis.tuser_o  = tuser_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state    <= IDLE;
         pop_left <= '0;
         wait_cnt <= '0;
         partial  <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (full_go) begin
                  state    <= BURST;
                  pop_left <= LEN_FULL;
                  partial  <= 1'b0;
                  wait_cnt <= '0;
               end else if (tmo_go) begin
                  // Words present now form the burst;
                  // later writes wait for the next one.
                  state    <= BURST;
                  pop_left <= fifo_used_words_i;
                  partial  <= 1'b1;
                  wait_cnt <= '0;
               end else if (fifo_empty_i) begin
                  wait_cnt <= '0;
               end else if (wait_cnt != WAIT_MAX) begin
                  wait_cnt <= wait_cnt + W_ONE;
               end
            end
            BURST: begin
               if (pop) begin
                  pop_left <= pop_left - PL_ONE;
                  if (pop_left == PL_ONE) begin
                     state <= IDLE;
                  end
               end
            end
         endcase
      end
   end

   // One-entry output register; holds until accepted.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         tdata_q  <= '0;
         tvalid_q <= 1'b0;
         tlast_q  <= 1'b0;
         tuser_q  <= 1'b0;
      end else if (pop) begin
         tdata_q  <= fifo_rd_data_i;
         tvalid_q <= 1'b1;
         tlast_q  <= (pop_left == PL_ONE);
         tuser_q  <= partial;
      end else if (axis.tready_i) begin
         tvalid_q <= 1'b0;
         tlast_q  <= 1'b0;
         tuser_q  <= 1'b0;
      end
   end

endmodule
